// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared state encoding and default constants for the fetch PC generator.
package pc_gen_pkg;

   typedef enum logic [1:0] {
      BOOT  = 2'd0,
      RUN   = 2'd1,
      FLUSH = 2'd2
   } pc_state_e;

   localparam int          PC_WIDTH        = 32;
   localparam int          PC_INC          = 4;
   localparam logic [31:0] PC_RESET_VECTOR = 32'h0000_0000;
   localparam logic [31:0] PC_TRAP_VECTOR  = 32'h0000_0004;
   localparam int          CNT_W           = 3;

endpackage

// File: rtl/pc_incrementer.sv
// pc_incrementer: combinational WIDTH-bit +INC adder, wraps modulo 2^WIDTH.
module pc_incrementer #(
   parameter int WIDTH = 32,
   parameter int INC   = 4
) (
   input  logic [WIDTH-1:0] pc_i,
   output logic [WIDTH-1:0] pc_next_o
);

   assign pc_next_o = pc_i + WIDTH'(INC);

endmodule

// File: rtl/pc_gen_unit.sv
// pc_gen_unit: fetch PC register with redirect, stall and post-redirect bubbles.
// Optional misaligned-redirect trap enabled by defining PC_MISALIGN_TRAP_EN.
module pc_gen_unit
   import pc_gen_pkg::*;
#(
   parameter int               WIDTH        = PC_WIDTH,
   parameter int               INC          = PC_INC,
   parameter logic [WIDTH-1:0] RESET_VECTOR = WIDTH'(PC_RESET_VECTOR),
   parameter int               FLUSH_CYCLES = 1,
   parameter int               ALIGN_BITS   = 2,
   parameter logic [WIDTH-1:0] TRAP_VECTOR  = WIDTH'(PC_TRAP_VECTOR)
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             stall_i,
   input  logic             redirect_i,
   input  logic [WIDTH-1:0] redirect_addr_i,
   output logic [WIDTH-1:0] pc_out_o,
   output logic [WIDTH-1:0] pc_plus_inc_o,
   output logic             valid_o,
   output logic             misalign_o
);

   localparam logic [WIDTH-1:0] ALIGN_MASK = {WIDTH{1'b1}} << ALIGN_BITS;
   localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES);

   pc_state_e        state_q;
   logic [CNT_W-1:0] cnt_q;
   logic [WIDTH-1:0] pc_q;
   logic [WIDTH-1:0] pc_inc;
   logic [WIDTH-1:0] target;
   logic             valid_q;
   logic             misalign_q;
   logic             bad_addr;

   pc_incrementer #(
      .WIDTH(WIDTH),
      .INC  (INC)
   ) u_inc (
      .pc_i     (pc_q),
      .pc_next_o(pc_inc)
   );

`ifdef PC_MISALIGN_TRAP_EN
   assign bad_addr = |(redirect_addr_i & ~ALIGN_MASK);
`else
   assign bad_addr = 1'b0;
`endif

   assign target = bad_addr ? TRAP_VECTOR : redirect_addr_i & ALIGN_MASK;

   // Redirect beats stall so a taken branch target is never dropped.
   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state_q    <= BOOT;
         cnt_q      <= '0;
         pc_q       <= RESET_VECTOR;
         valid_q    <= 1'b0;
         misalign_q <= 1'b0;
      end else if (redirect_i) begin
         pc_q       <= target;
         misalign_q <= bad_addr;
         cnt_q      <= FLUSH_LOAD;
         state_q    <= (FLUSH_LOAD == '0) ? RUN : FLUSH;
         valid_q    <= (FLUSH_LOAD == '0);
      end else begin
         misalign_q <= 1'b0;
         case (state_q)
            BOOT: begin
               state_q <= RUN;
               valid_q <= 1'b1;
            end
            RUN: begin
               if (!stall_i) pc_q <= pc_inc;
               valid_q <= 1'b1;
            end
            FLUSH: begin
               cnt_q   <= cnt_q - CNT_W'(1);
               state_q <= (cnt_q == CNT_W'(1)) ? RUN : FLUSH;
               valid_q <= (cnt_q == CNT_W'(1));
            end
            default: begin
               state_q <= BOOT;
               valid_q <= 1'b0;
            end
         endcase
      end
   end

   assign pc_out_o      = pc_q;
   assign pc_plus_inc_o = pc_inc;
   assign valid_o       = valid_q;
   assign misalign_o    = misalign_q;

endmodule
